// File: rtl/queue_tag_tracker.sv
// Head/tail tag manager for multi-port circular queues with wrap flag,
// per-lane readiness/validity, tail rollback and whole-queue flush.
module queue_tag_tracker #(
    parameter int Depth       = 8,
    parameter int EnqWidth    = 2,
    parameter int DeqWidth    = 2,
    parameter bit EnqCollapse = 1'b0,
    parameter bit DeqCollapse = 1'b0,
    parameter bit InitFull    = 1'b0,
    localparam int PtrWidth   = $clog2(Depth),
    localparam int TagWidth   = PtrWidth + 1,
    localparam int CntWidth   = $clog2(Depth + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [EnqWidth-1:0]          enq_eval_i,
    input  logic [EnqWidth-1:0]          enq_fire_i,
    output logic [EnqWidth-1:0]          enq_rdy_o,
    output logic [EnqWidth*TagWidth-1:0] enq_tag_o,
    input  logic [DeqWidth-1:0]          deq_eval_i,
    input  logic [DeqWidth-1:0]          deq_fire_i,
    output logic [DeqWidth-1:0]          deq_vld_o,
    output logic [DeqWidth*TagWidth-1:0] deq_tag_o,
    input  logic                         rollback_i,
    input  logic [TagWidth-1:0]          rollback_tag_i,
    input  logic                         flush_i,
    output logic [CntWidth-1:0]          count_o,
    output logic [CntWidth-1:0]          free_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int SumWidth  = PtrWidth + 1;
    localparam int DistWidth = PtrWidth + 2;

    // Advance by delta entries; one subtraction suffices since delta <= Depth.
    function automatic logic [TagWidth-1:0] tag_advance(input logic [TagWidth-1:0] tag,
                                                        input logic [CntWidth-1:0] delta);
        logic [SumWidth-1:0] sum;
        logic                flag;
        sum  = SumWidth'(tag[PtrWidth-1:0]) + SumWidth'(delta);
        flag = tag[PtrWidth];
        if (sum >= SumWidth'(Depth)) begin
            sum  = sum - SumWidth'(Depth);
            flag = ~flag;
        end
        return {flag, sum[PtrWidth-1:0]};
    endfunction

    // Entries from lo up to (not including) hi; illegal orderings yield values above Depth.
    function automatic logic [DistWidth-1:0] tag_dist(input logic [TagWidth-1:0] hi,
                                                      input logic [TagWidth-1:0] lo);
        logic [DistWidth-1:0] d;
        if (hi[PtrWidth] == lo[PtrWidth]) begin
            d = DistWidth'(hi[PtrWidth-1:0]) - DistWidth'(lo[PtrWidth-1:0]);
        end else begin
            d = DistWidth'(Depth) - DistWidth'(lo[PtrWidth-1:0]) + DistWidth'(hi[PtrWidth-1:0]);
        end
        return d;
    endfunction

    logic [TagWidth-1:0]  enq_tag_q, enq_tag_d;
    logic [TagWidth-1:0]  deq_tag_q, deq_tag_d;
    logic [DistWidth-1:0] occ;

    logic [TagWidth-1:0]  enq_lane_tag [EnqWidth];
    logic [CntWidth-1:0]  enq_slot     [EnqWidth];
    logic [EnqWidth-1:0]  enq_consume, enq_efire;
    logic [CntWidth-1:0]  enq_adv;
    logic                 enq_prefix_ok;

    logic [TagWidth-1:0]  deq_lane_tag [DeqWidth];
    logic [CntWidth-1:0]  deq_slot     [DeqWidth];
    logic [DeqWidth-1:0]  deq_consume, deq_efire;
    logic [CntWidth-1:0]  deq_adv;
    logic                 deq_prefix_ok;

    logic [TagWidth-1:0]  deq_tag_post;
    logic                 rollback_ok;

    assign occ     = tag_dist(enq_tag_q, deq_tag_q);
    assign count_o = CntWidth'(occ);
    assign free_o  = CntWidth'(Depth) - count_o;
    assign full_o  = (count_o == CntWidth'(Depth));
    assign empty_o = (count_o == '0);

    assign enq_consume = EnqCollapse ? enq_eval_i : {EnqWidth{1'b1}};
    assign deq_consume = DeqCollapse ? deq_eval_i : {DeqWidth{1'b1}};

    always_comb begin
        logic gap;
        enq_tag_o       = '0;
        enq_lane_tag[0] = enq_tag_q;
        enq_slot[0]     = '0;
        for (int i = 1; i < EnqWidth; i++) begin
            if (enq_consume[i-1]) begin
                enq_lane_tag[i] = tag_advance(enq_lane_tag[i-1], CntWidth'(1));
                enq_slot[i]     = enq_slot[i-1] + CntWidth'(1);
            end else begin
                enq_lane_tag[i] = enq_lane_tag[i-1];
                enq_slot[i]     = enq_slot[i-1];
            end
        end
        enq_adv       = '0;
        enq_prefix_ok = 1'b1;
        gap           = 1'b0;
        for (int i = 0; i < EnqWidth; i++) begin
            enq_rdy_o[i] = (enq_slot[i] < free_o);
            enq_efire[i] = enq_fire_i[i] & enq_rdy_o[i];
            enq_adv      = enq_adv + CntWidth'(enq_efire[i]);
            enq_tag_o[i*TagWidth +: TagWidth] = enq_lane_tag[i];
            if (enq_efire[i] && (!enq_consume[i] || gap)) enq_prefix_ok = 1'b0;
            if (enq_consume[i] && !enq_efire[i]) gap = 1'b1;
        end
    end

    always_comb begin
        logic gap;
        deq_tag_o       = '0;
        deq_lane_tag[0] = deq_tag_q;
        deq_slot[0]     = '0;
        for (int i = 1; i < DeqWidth; i++) begin
            if (deq_consume[i-1]) begin
                deq_lane_tag[i] = tag_advance(deq_lane_tag[i-1], CntWidth'(1));
                deq_slot[i]     = deq_slot[i-1] + CntWidth'(1);
            end else begin
                deq_lane_tag[i] = deq_lane_tag[i-1];
                deq_slot[i]     = deq_slot[i-1];
            end
        end
        deq_adv       = '0;
        deq_prefix_ok = 1'b1;
        gap           = 1'b0;
        for (int i = 0; i < DeqWidth; i++) begin
            deq_vld_o[i] = (deq_slot[i] < count_o);
            deq_efire[i] = deq_fire_i[i] & deq_vld_o[i];
            deq_adv      = deq_adv + CntWidth'(deq_efire[i]);
            deq_tag_o[i*TagWidth +: TagWidth] = deq_lane_tag[i];
            if (deq_efire[i] && (!deq_consume[i] || gap)) deq_prefix_ok = 1'b0;
            if (deq_consume[i] && !deq_efire[i]) gap = 1'b1;
        end
    end

    assign deq_tag_post = tag_advance(deq_tag_q, deq_adv);
    assign rollback_ok  = tag_dist(rollback_tag_i, deq_tag_post) <= tag_dist(enq_tag_q, deq_tag_post);

    // Priority: flush over rollback over fires; dequeue still retires during rollback.
    always_comb begin
        enq_tag_d = enq_tag_q;
        deq_tag_d = deq_tag_q;
        if (flush_i) begin
            enq_tag_d = InitFull ? {~deq_tag_q[PtrWidth], deq_tag_q[PtrWidth-1:0]} : deq_tag_q;
        end else begin
            deq_tag_d = deq_tag_post;
            enq_tag_d = rollback_i ? rollback_tag_i : tag_advance(enq_tag_q, enq_adv);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enq_tag_q <= {InitFull, {PtrWidth{1'b0}}};
            deq_tag_q <= '0;
        end else begin
            enq_tag_q <= enq_tag_d;
            deq_tag_q <= deq_tag_d;
        end
    end

    a_enq_prefix: assert property (@(posedge clk) disable iff (rst)
        (!flush_i && !rollback_i) |-> enq_prefix_ok);
    a_deq_prefix: assert property (@(posedge clk) disable iff (rst)
        !flush_i |-> deq_prefix_ok);
    a_rollback_range: assert property (@(posedge clk) disable iff (rst)
        (rollback_i && !flush_i) |-> rollback_ok);

endmodule

// File: tb/tb_queue_tag_tracker.sv
// Directed scoreboard bench for queue_tag_tracker: two Depth=6 instances,
// one empty-reset with enqueue collapse, one full-reset with dequeue collapse.
module tb_queue_tag_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [1:0] a_enq_eval, a_enq_fire, a_enq_rdy, a_deq_eval, a_deq_fire, a_deq_vld;
    logic [7:0] a_enq_tag, a_deq_tag;
    logic       a_rb, a_flush, a_full, a_empty;
    logic [3:0] a_rb_tag;
    logic [2:0] a_cnt, a_free;

    logic [1:0] b_enq_eval, b_enq_fire, b_enq_rdy, b_deq_eval, b_deq_fire, b_deq_vld;
    logic [7:0] b_enq_tag, b_deq_tag;
    logic       b_rb, b_flush, b_full, b_empty;
    logic [3:0] b_rb_tag;
    logic [2:0] b_cnt, b_free;

    queue_tag_tracker #(.Depth(6), .EnqWidth(2), .DeqWidth(2),
                        .EnqCollapse(1'b1), .DeqCollapse(1'b0), .InitFull(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .enq_eval_i(a_enq_eval), .enq_fire_i(a_enq_fire), .enq_rdy_o(a_enq_rdy), .enq_tag_o(a_enq_tag),
        .deq_eval_i(a_deq_eval), .deq_fire_i(a_deq_fire), .deq_vld_o(a_deq_vld), .deq_tag_o(a_deq_tag),
        .rollback_i(a_rb), .rollback_tag_i(a_rb_tag), .flush_i(a_flush),
        .count_o(a_cnt), .free_o(a_free), .full_o(a_full), .empty_o(a_empty));

    queue_tag_tracker #(.Depth(6), .EnqWidth(2), .DeqWidth(2),
                        .EnqCollapse(1'b0), .DeqCollapse(1'b1), .InitFull(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .enq_eval_i(b_enq_eval), .enq_fire_i(b_enq_fire), .enq_rdy_o(b_enq_rdy), .enq_tag_o(b_enq_tag),
        .deq_eval_i(b_deq_eval), .deq_fire_i(b_deq_fire), .deq_vld_o(b_deq_vld), .deq_tag_o(b_deq_tag),
        .rollback_i(b_rb), .rollback_tag_i(b_rb_tag), .flush_i(b_flush),
        .count_o(b_cnt), .free_o(b_free), .full_o(b_full), .empty_o(b_empty));

    typedef struct {
        string      name;
        bit         inst;
        logic [3:0] et0, et1, dt0, dt1;
        logic [2:0] cnt, free;
        logic [1:0] rdy, vld;
        logic       full, empty;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic push(input string nm, input bit inst,
                        input logic [3:0] et0, input logic [3:0] et1,
                        input logic [3:0] dt0, input logic [3:0] dt1,
                        input logic [2:0] cnt, input logic [2:0] free,
                        input logic [1:0] rdy, input logic [1:0] vld,
                        input logic full, input logic empty);
        exp_t e;
        e.name = nm; e.inst = inst;
        e.et0 = et0; e.et1 = et1; e.dt0 = dt0; e.dt1 = dt1;
        e.cnt = cnt; e.free = free; e.rdy = rdy; e.vld = vld;
        e.full = full; e.empty = empty;
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input string f, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%0h expected=%0h", nm, f, obs, exp);
        end
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard underflow observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        if (!e.inst) begin
            cmp(e.name, "enq_tag0", 8'(a_enq_tag[3:0]), 8'(e.et0));
            cmp(e.name, "enq_tag1", 8'(a_enq_tag[7:4]), 8'(e.et1));
            cmp(e.name, "deq_tag0", 8'(a_deq_tag[3:0]), 8'(e.dt0));
            cmp(e.name, "deq_tag1", 8'(a_deq_tag[7:4]), 8'(e.dt1));
            cmp(e.name, "count",    8'(a_cnt),   8'(e.cnt));
            cmp(e.name, "free",     8'(a_free),  8'(e.free));
            cmp(e.name, "enq_rdy",  8'(a_enq_rdy), 8'(e.rdy));
            cmp(e.name, "deq_vld",  8'(a_deq_vld), 8'(e.vld));
            cmp(e.name, "full",     8'(a_full),  8'(e.full));
            cmp(e.name, "empty",    8'(a_empty), 8'(e.empty));
        end else begin
            cmp(e.name, "enq_tag0", 8'(b_enq_tag[3:0]), 8'(e.et0));
            cmp(e.name, "enq_tag1", 8'(b_enq_tag[7:4]), 8'(e.et1));
            cmp(e.name, "deq_tag0", 8'(b_deq_tag[3:0]), 8'(e.dt0));
            cmp(e.name, "deq_tag1", 8'(b_deq_tag[7:4]), 8'(e.dt1));
            cmp(e.name, "count",    8'(b_cnt),   8'(e.cnt));
            cmp(e.name, "free",     8'(b_free),  8'(e.free));
            cmp(e.name, "enq_rdy",  8'(b_enq_rdy), 8'(e.rdy));
            cmp(e.name, "deq_vld",  8'(b_deq_vld), 8'(e.vld));
            cmp(e.name, "full",     8'(b_full),  8'(e.full));
            cmp(e.name, "empty",    8'(b_empty), 8'(e.empty));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        a_enq_fire = 2'b00; a_deq_fire = 2'b00; a_rb = 1'b0; a_flush = 1'b0;
        b_enq_fire = 2'b00; b_deq_fire = 2'b00; b_rb = 1'b0; b_flush = 1'b0;
    endtask

    // Apply the driven controls for one edge, then compare post-edge outputs.
    task automatic step();
        tick();
        clear_ctl();
        check();
    endtask

    task automatic check_now();
        #1;
        check();
    endtask

    initial begin
        rst = 1'b1;
        clear_ctl();
        a_enq_eval = 2'b00; a_deq_eval = 2'b11; a_rb_tag = 4'd0;
        b_enq_eval = 2'b11; b_deq_eval = 2'b11; b_rb_tag = 4'd0;
        repeat (2) tick();
        rst = 1'b0;

        push("a_reset", 0, 4'd0, 4'd0, 4'd0, 4'd1, 3'd0, 3'd6, 2'b11, 2'b00, 1'b0, 1'b1);
        check_now();
        push("b_reset", 1, 4'd8, 4'd9, 4'd0, 4'd1, 3'd6, 3'd0, 2'b00, 2'b11, 1'b1, 1'b0);
        check_now();
        push("a_idle_edge", 0, 4'd0, 4'd0, 4'd0, 4'd1, 3'd0, 3'd6, 2'b11, 2'b00, 1'b0, 1'b1);
        step();

        // Fill the empty-reset queue two per cycle, then push into a full queue.
        a_enq_eval = 2'b11;
        a_enq_fire = 2'b11;
        push("a_enq1", 0, 4'd2, 4'd3, 4'd0, 4'd1, 3'd2, 3'd4, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        a_enq_fire = 2'b11;
        push("a_enq2", 0, 4'd4, 4'd5, 4'd0, 4'd1, 3'd4, 3'd2, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        a_enq_fire = 2'b11;
        push("a_enq3_full", 0, 4'd8, 4'd9, 4'd0, 4'd1, 3'd6, 3'd0, 2'b00, 2'b11, 1'b1, 1'b0);
        step();
        a_enq_fire = 2'b11;
        push("a_enq_when_full", 0, 4'd8, 4'd9, 4'd0, 4'd1, 3'd6, 3'd0, 2'b00, 2'b11, 1'b1, 1'b0);
        step();
        a_deq_fire = 2'b11;
        push("a_deq2", 0, 4'd8, 4'd9, 4'd2, 4'd3, 3'd4, 3'd2, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        a_enq_fire = 2'b11; a_deq_fire = 2'b11;
        push("a_enq_deq", 0, 4'd10, 4'd11, 4'd4, 4'd5, 3'd4, 3'd2, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        a_enq_fire = 2'b11;
        push("a_refill", 0, 4'd12, 4'd13, 4'd4, 4'd5, 3'd6, 3'd0, 2'b00, 2'b11, 1'b1, 1'b0);
        step();
        a_enq_fire = 2'b11; a_deq_fire = 2'b01;
        push("a_full_deq_enq", 0, 4'd12, 4'd13, 4'd5, 4'd8, 3'd5, 3'd1, 2'b01, 2'b11, 1'b0, 1'b0);
        step();
        a_flush = 1'b1; a_enq_fire = 2'b11; a_deq_fire = 2'b11;
        push("a_flush", 0, 4'd5, 4'd8, 4'd5, 4'd8, 3'd0, 3'd6, 2'b11, 2'b00, 1'b0, 1'b1);
        step();

        // Collapse: lane 1 shares lane 0's tag when lane 0 is not evaluating.
        a_enq_eval = 2'b10;
        push("a_collapse_10", 0, 4'd5, 4'd5, 4'd5, 4'd8, 3'd0, 3'd6, 2'b11, 2'b00, 1'b0, 1'b1);
        check_now();
        a_enq_eval = 2'b11;
        push("a_collapse_11", 0, 4'd5, 4'd8, 4'd5, 4'd8, 3'd0, 3'd6, 2'b11, 2'b00, 1'b0, 1'b1);
        check_now();
        a_enq_fire = 2'b11;
        push("a_wrap_enq", 0, 4'd9, 4'd10, 4'd5, 4'd8, 3'd2, 3'd4, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        a_enq_eval = 2'b10; a_enq_fire = 2'b10;
        push("a_collapse_fire", 0, 4'd10, 4'd10, 4'd5, 4'd8, 3'd3, 3'd3, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        a_enq_eval = 2'b11;

        // Asynchronous reset landing between edges of an enqueue burst.
        a_enq_fire = 2'b11;
        tick();
        #2;
        rst = 1'b1;
        push("a_async_reset", 0, 4'd0, 4'd1, 4'd0, 4'd1, 3'd0, 3'd6, 2'b11, 2'b00, 1'b0, 1'b1);
        check_now();
        clear_ctl();
        tick();
        rst = 1'b0;
        push("a_post_release", 0, 4'd0, 4'd1, 4'd0, 4'd1, 3'd0, 3'd6, 2'b11, 2'b00, 1'b0, 1'b1);
        step();

        // Rollback with a simultaneous dequeue; the enqueue fire is discarded.
        a_enq_fire = 2'b11;
        push("a_rb_setup1", 0, 4'd2, 4'd3, 4'd0, 4'd1, 3'd2, 3'd4, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        a_enq_fire = 2'b11; a_deq_fire = 2'b01;
        push("a_rb_setup2", 0, 4'd4, 4'd5, 4'd1, 4'd2, 3'd3, 3'd3, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        a_rb = 1'b1; a_rb_tag = 4'd2; a_deq_fire = 2'b01; a_enq_fire = 2'b11;
        push("a_rollback", 0, 4'd2, 4'd3, 4'd2, 4'd3, 3'd0, 3'd6, 2'b11, 2'b00, 1'b0, 1'b1);
        step();

        // Full-reset instance: drain three entries, then flush with rollback.
        b_deq_fire = 2'b11;
        push("b_deq2", 1, 4'd8, 4'd9, 4'd2, 4'd3, 3'd4, 3'd2, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        b_deq_eval = 2'b10;
        push("b_deq_collapse", 1, 4'd8, 4'd9, 4'd2, 4'd2, 3'd4, 3'd2, 2'b11, 2'b11, 1'b0, 1'b0);
        check_now();
        b_deq_fire = 2'b10;
        push("b_deq1", 1, 4'd8, 4'd9, 4'd3, 4'd3, 3'd3, 3'd3, 2'b11, 2'b11, 1'b0, 1'b0);
        step();
        b_flush = 1'b1; b_rb = 1'b1; b_rb_tag = 4'd4; b_enq_fire = 2'b11; b_deq_fire = 2'b10;
        push("b_flush_wins", 1, 4'd11, 4'd12, 4'd3, 4'd3, 3'd6, 3'd0, 2'b00, 2'b11, 1'b1, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
